// File: rtl/vanilla_sb_writeback_arbiter.sv
// Writeback arbiter: shares the int/float RF write ports and scoreboard clears between
// buffered remote load responses and the idiv/fdiv units, and tracks remote-load credits.

module vanilla_sb_writeback_port #(
  parameter int data_width_p     = 32,
  parameter int reg_addr_width_p = 5,
  parameter int starve_limit_p   = 4
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        stall_all,
  input  logic                        buf_v,
  input  logic [reg_addr_width_p-1:0] buf_rd,
  input  logic [data_width_p-1:0]     buf_data,
  input  logic                        unit_v,
  input  logic [reg_addr_width_p-1:0] unit_rd,
  input  logic [data_width_p-1:0]     unit_data,
  output logic                        w_v,
  output logic [reg_addr_width_p-1:0] w_addr,
  output logic [data_width_p-1:0]     w_data,
  output logic                        unit_yumi,
  output logic                        buf_gnt
);
  localparam int SW = $clog2(starve_limit_p + 1);

  logic [SW-1:0] starve;
  logic          starved;
  logic          unit_win;

  assign starved  = (starve == SW'(starve_limit_p));
  // Buffered response wins by default since draining it returns network credit.
  assign unit_win = !stall_all && unit_v && (!buf_v || starved);
  assign buf_gnt  = !stall_all && buf_v && !unit_win;

  assign w_v       = unit_win || buf_gnt;
  assign w_addr    = unit_win ? unit_rd : buf_rd;
  assign w_data    = unit_win ? unit_data : buf_data;
  assign unit_yumi = unit_win;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i)                   starve <= '0;
    else if (!stall_all) begin
      if (!unit_v || unit_win)      starve <= '0;
      else if (!starved)            starve <= starve + 1'b1;
    end
  end
endmodule

module vanilla_sb_writeback_arbiter #(
  parameter int data_width_p      = 32,
  parameter int reg_addr_width_p  = 5,
  parameter int max_out_credits_p = 16,
  parameter int starve_limit_p    = 4
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        stall_all,
  input  logic                        remote_issue_i,
  output logic                        credit_avail_o,
  input  logic                        remote_v_i,
  input  logic [data_width_p-1:0]     remote_data_i,
  input  logic [reg_addr_width_p-1:0] remote_rd_i,
  input  logic                        remote_float_i,
  output logic                        remote_ready_o,
  input  logic                        idiv_v_i,
  input  logic [data_width_p-1:0]     idiv_data_i,
  input  logic [reg_addr_width_p-1:0] idiv_rd_i,
  output logic                        idiv_yumi_o,
  input  logic                        fdiv_v_i,
  input  logic [data_width_p-1:0]     fdiv_data_i,
  input  logic [reg_addr_width_p-1:0] fdiv_rd_i,
  output logic                        fdiv_yumi_o,
  output logic                        int_w_v_o,
  output logic [reg_addr_width_p-1:0] int_w_addr_o,
  output logic [data_width_p-1:0]     int_w_data_o,
  output logic                        float_w_v_o,
  output logic [reg_addr_width_p-1:0] float_w_addr_o,
  output logic [data_width_p-1:0]     float_w_data_o,
  output logic                        int_sb_clear,
  output logic [reg_addr_width_p-1:0] int_sb_clear_id,
  output logic                        float_sb_clear,
  output logic [reg_addr_width_p-1:0] float_sb_clear_id
);
  localparam int NUM_LANES = 2;  // lane 0: int/idiv, lane 1: float/fdiv
  localparam int CW        = $clog2(max_out_credits_p + 1);
  localparam logic [CW-1:0] CMAX = CW'(max_out_credits_p);

  typedef struct packed {
    logic [data_width_p-1:0]     data;
    logic [reg_addr_width_p-1:0] rd;
    logic                        is_float;
  } resp_t;

  resp_t   buf_q;
  logic    buf_v;
  logic    buf_gnt;
  logic    accept;
  logic [CW-1:0] credit_cnt;

  logic [NUM_LANES-1:0]                       lane_buf_v, lane_unit_v;
  logic [NUM_LANES-1:0][reg_addr_width_p-1:0] lane_unit_rd, lane_w_addr;
  logic [NUM_LANES-1:0][data_width_p-1:0]     lane_unit_data, lane_w_data;
  logic [NUM_LANES-1:0]                       lane_w_v, lane_yumi, lane_buf_gnt;

  assign lane_buf_v     = {buf_v && buf_q.is_float, buf_v && !buf_q.is_float};
  assign lane_unit_v    = {fdiv_v_i, idiv_v_i};
  assign lane_unit_rd   = {fdiv_rd_i, idiv_rd_i};
  assign lane_unit_data = {fdiv_data_i, idiv_data_i};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    vanilla_sb_writeback_port #(
      .data_width_p(data_width_p), .reg_addr_width_p(reg_addr_width_p),
      .starve_limit_p(starve_limit_p)
    ) u_port (
      .clk_i(clk_i), .reset_i(reset_i), .stall_all(stall_all),
      .buf_v(lane_buf_v[g]), .buf_rd(buf_q.rd), .buf_data(buf_q.data),
      .unit_v(lane_unit_v[g]), .unit_rd(lane_unit_rd[g]), .unit_data(lane_unit_data[g]),
      .w_v(lane_w_v[g]), .w_addr(lane_w_addr[g]), .w_data(lane_w_data[g]),
      .unit_yumi(lane_yumi[g]), .buf_gnt(lane_buf_gnt[g])
    );
  end

  assign buf_gnt        = |lane_buf_gnt;
  assign remote_ready_o = !buf_v || buf_gnt;
  assign accept         = remote_v_i && remote_ready_o;
  assign credit_avail_o = (credit_cnt < CMAX);

  assign int_w_v_o         = lane_w_v[0];
  assign int_w_addr_o      = lane_w_addr[0];
  assign int_w_data_o      = lane_w_data[0];
  assign int_sb_clear      = lane_w_v[0];
  assign int_sb_clear_id   = lane_w_addr[0];
  assign float_w_v_o       = lane_w_v[1];
  assign float_w_addr_o    = lane_w_addr[1];
  assign float_w_data_o    = lane_w_data[1];
  assign float_sb_clear    = lane_w_v[1];
  assign float_sb_clear_id = lane_w_addr[1];
  assign idiv_yumi_o       = lane_yumi[0];
  assign fdiv_yumi_o       = lane_yumi[1];

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      buf_v <= 1'b0;
      buf_q <= '0;
    end else if (accept) begin
      buf_v <= 1'b1;
      buf_q <= '{data: remote_data_i, rd: remote_rd_i, is_float: remote_float_i};
    end else if (buf_gnt) begin
      buf_v <= 1'b0;
    end
  end

  // Issue and return in the same cycle cancel; out-of-range updates saturate.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      credit_cnt <= '0;
    end else begin
      assert (!(remote_issue_i && !accept && credit_cnt == CMAX))
        else $error("remote issue with no credit available");
      assert (!(accept && !remote_issue_i && credit_cnt == '0))
        else $error("remote response with no outstanding load");
      if (remote_issue_i && !accept && credit_cnt != CMAX)
        credit_cnt <= credit_cnt + 1'b1;
      else if (accept && !remote_issue_i && credit_cnt != '0)
        credit_cnt <= credit_cnt - 1'b1;
    end
  end
endmodule
